// File: rtl/sr_latch_driver.sv
// Button front-end for the clocked SR latch: synchronizes and debounces the set/clear
// buttons, queues one request per channel and issues non-overlapping active-low strobes.
module sr_latch_driver #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic lat_c,
    output logic lat_s_n,
    output logic lat_r_n,
    output logic busy
);

    localparam int CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int PW     = $clog2(PH_MAX + 1);

    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYCLES - 1);

    // Channel index 0 is set, index 1 is clear.
    localparam int CH_SET = 0;
    localparam int CH_CLR = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    db_r;
    logic [1:0]    diff_s;
    logic [1:0]    flip_s;
    logic [1:0]    rise_s;
    logic [1:0]    pend_r;
    logic [1:0]    take_s;

    state_t        state_r;
    state_t        state_s;
    logic          sel_clr_r;
    logic          sel_clr_s;
    logic [PW-1:0] ph_cnt_r;
    logic [PW-1:0] ph_cnt_s;

    logic          lat_c_r;
    logic          lat_s_n_r;
    logic          lat_r_n_r;
    logic          busy_r;
    logic          lat_c_s;
    logic          lat_s_n_s;
    logic          lat_r_n_s;
    logic          busy_s;

    // Two-flop synchronizer for both raw buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= {clr_btn, set_btn};
            sync2_r <= sync1_r;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_deb
            logic [CW-1:0] cnt_r;

            // The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            assign diff_s[g] = sync2_r[g] ^ db_r[g];
            assign flip_s[g] = diff_s[g] && (cnt_r == DB_LAST);
            assign rise_s[g] = flip_s[g] && sync2_r[g];

            // Per-channel debounce counter and debounced level.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_r   <= {CW{1'b0}};
                    db_r[g] <= 1'b0;
                end else if (!diff_s[g]) begin
                    cnt_r   <= {CW{1'b0}};
                end else if (flip_s[g]) begin
                    cnt_r   <= {CW{1'b0}};
                    db_r[g] <= sync2_r[g];
                end else begin
                    cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    // Pending-request flags: a new press during the taking edge is kept, repeats merge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= 2'b00;
        end else begin
            pend_r <= (pend_r & ~take_s) | rise_s;
        end
    end

    // Next-state logic; the end of GAP launches directly if a request is waiting.
    always_comb begin
        state_s   = state_r;
        sel_clr_s = sel_clr_r;
        ph_cnt_s  = ph_cnt_r;
        take_s    = 2'b00;
        case (state_r)
            IDLE, GAP: begin
                if ((state_r == GAP) && (ph_cnt_r != GAP_LAST)) begin
                    ph_cnt_s = ph_cnt_r + {{(PW-1){1'b0}}, 1'b1};
                end else if (pend_r[CH_CLR]) begin
                    state_s        = DRIVE;
                    sel_clr_s      = 1'b1;
                    ph_cnt_s       = {PW{1'b0}};
                    take_s[CH_CLR] = 1'b1;
                end else if (pend_r[CH_SET]) begin
                    state_s        = DRIVE;
                    sel_clr_s      = 1'b0;
                    ph_cnt_s       = {PW{1'b0}};
                    take_s[CH_SET] = 1'b1;
                end else begin
                    state_s  = IDLE;
                    ph_cnt_s = {PW{1'b0}};
                end
            end
            DRIVE: begin
                if (ph_cnt_r == PULSE_LAST) begin
                    state_s  = GAP;
                    ph_cnt_s = {PW{1'b0}};
                end else begin
                    ph_cnt_s = ph_cnt_r + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s   = IDLE;
                sel_clr_s = 1'b0;
                ph_cnt_s  = {PW{1'b0}};
            end
        endcase
    end

    // Outputs decoded from the next state so they change on the same edge as the state.
    always_comb begin
        lat_c_s   = 1'b0;
        lat_s_n_s = 1'b1;
        lat_r_n_s = 1'b1;
        busy_s    = 1'b0;
        if (state_s == DRIVE) begin
            lat_c_s   = 1'b1;
            lat_s_n_s = sel_clr_s;
            lat_r_n_s = ~sel_clr_s;
            busy_s    = 1'b1;
        end else begin
            busy_s    = (state_s != IDLE);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            sel_clr_r <= 1'b0;
            ph_cnt_r  <= {PW{1'b0}};
        end else begin
            state_r   <= state_s;
            sel_clr_r <= sel_clr_s;
            ph_cnt_r  <= ph_cnt_s;
        end
    end

    // Registered latch-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_c_r   <= 1'b0;
            lat_s_n_r <= 1'b1;
            lat_r_n_r <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            lat_c_r   <= lat_c_s;
            lat_s_n_r <= lat_s_n_s;
            lat_r_n_r <= lat_r_n_s;
            busy_r    <= busy_s;
        end
    end

    assign lat_c   = lat_c_r;
    assign lat_s_n = lat_s_n_r;
    assign lat_r_n = lat_r_n_r;
    assign busy    = busy_r;

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Front-end for the clocked SR latch lab module: turns two raw, bouncing push-buttons (set, clear) into clean, non-overlapping, active-low set/reset strobes plus the latch clock/enable. It synchronizes and debounces each button, queues one request per channel, and issues fixed-width pulses with a guard gap. The latch is never driven with S and R low together.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized input must differ from its debounced state before the state flips (board build overrides to 500000); must be ≥ 2
- PULSE_CYCLES, 4, cycles lat_c is high and one strobe is low per request; ≥ 1
- GAP_CYCLES, 2, idle cycles after each pulse before the next may start; ≥ 1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- set_btn  in  1  raw set button, active-high, asynchronous to clk
- clr_btn  in  1  raw clear button, active-high, asynchronous to clk
- lat_c  out  1  latch clock/enable to the SR latch
- lat_s_n  out  1  active-low set strobe
- lat_r_n  out  1  active-low reset strobe
- busy  out  1  high whenever FSM is not IDLE

## Operation
- Synchronizer: two flops per button, reset 0; sync2 is the only internal use of raw inputs.
- Debouncer, per channel: db (reset 0), counter of width clog2(DEBOUNCE_CYCLES), reset 0. sync2 == db → counter clears. sync2 != db → counter increments; on the edge where counter == DEBOUNCE_CYCLES-1 and sync2 != db, db <= sync2 and counter clears.
- Request: on the edge db goes 0→1, that channel's pend flag sets (reset 0). Further presses while pend is already set merge (no counting). Release (db 1→0) generates nothing.
- FSM states IDLE, DRIVE, GAP; reset IDLE.
  - IDLE: clr_pend → DRIVE as clear pulse, clr_pend cleared; else set_pend → DRIVE as set pulse, set_pend cleared; else stay.
  - DRIVE: PULSE_CYCLES cycles; lat_c=1; exactly the selected strobe low. Then GAP.
  - GAP: GAP_CYCLES cycles; lat_c=0, strobes 1. Then IDLE.
- Clear has priority when both pend flags are set; the set request stays pending and is serviced after GAP.
- pend flags continue to set during DRIVE/GAP.
- Outputs are registered from state; reset values: lat_c=0, lat_s_n=1, lat_r_n=1, busy=0.
- Invariants: lat_s_n & lat_r_n never both 0; lat_c=1 only in DRIVE; strobes low only while lat_c=1.
- Reset mid-operation: the next edge returns all registers to reset values, pending requests are dropped, and a pulse in progress is truncated. A button still held after reset is re-debounced and produces a new request.

## Timing
- Raw button first sampled high at edge 0 and held: db and pend set at edge D+1 (D = DEBOUNCE_CYCLES). FSM enters DRIVE at edge D+2, so the strobe falls and lat_c rises at edge D+2.
- Strobe and lat_c return at edge D+2+PULSE_CYCLES. busy falls at edge D+2+PULSE_CYCLES+GAP_CYCLES.
- Minimum spacing between strobe falling edges: PULSE_CYCLES+GAP_CYCLES cycles.
- Any input excursion shorter than D consecutive sync2 cycles is ignored entirely.

## Test plan
(D=16, P=4, G=2; edge 0 = first edge sampling the button high)
1. Reset: rst high 3 cycles, buttons low → lat_c=0, lat_s_n=1, lat_r_n=1, busy=0 from the first reset edge onward. No activity for 100 cycles.
2. Single set: set_btn held 30 cycles → lat_s_n=0 and lat_c=1 over edges 18–21; lat_r_n stays 1; busy high edges 18–23, low at 24. Exactly one pulse.
3. Bounce: set_btn alternates 5 cycles high / 5 low ×4, then low → no strobe, lat_c stays 0, busy stays 0.
4. Simultaneous: set_btn and clr_btn both rise at edge 0, held → lat_r_n low edges 18–21, gap 22–23, lat_s_n low edges 24–27. Never both low in the same cycle (assert every cycle).
5. Press while busy: set_btn at edge 0; clr_btn rises at edge 5 → set pulse edges 18–21; clear pulse edges 24–27 (clr pend set at 22, serviced after GAP).
6. Reset mid-DRIVE: set_btn held from edge 0 and released at edge 19; rst high at edge 19 for 2 cycles → outputs at reset values from edge 20, no further strobes for 100 cycles.
